// File: rtl/adc_emulator.sv
// Emulates the dual-channel serial ADC: fixed conversion timing, then MSB-first shift-out of two samples.
// Build option: ADC_EMU_PATTERN_EN replaces DATA_A/DATA_B with an internal counting pattern.
module adc_emulator #(
    parameter int DATA_W   = 16,
    parameter int CONV_DLY = 4,
    parameter int BUSY_CYC = 70
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CNVST_ADC,
    input  logic              CS_ADC,
    input  logic              SCLK_ADC,
    input  logic [DATA_W-1:0] DATA_A,
    input  logic [DATA_W-1:0] DATA_B,
    output logic              BUSY_ADC,
    output logic              DOUTA_ADC,
    output logic              DOUTB_ADC,
    output logic              CONV_DONE,
    output logic              OVERRUN,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(BUSY_CYC + CONV_DLY + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(CONV_DLY - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_FULL  = BIT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_BUSY  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              busy_d, ovr_d, load;

    logic [2:0]        cnv_sync, cs_sync, sclk_sync;
    logic              cnv_fall, cs_fall, sclk_fall;
    logic              cs_low;

    logic [DATA_W-1:0] sh_a, sh_b;
    logic [DATA_W-1:0] src_a, src_b;
    logic [BIT_W-1:0]  bit_cnt;

    // [0],[1] synchronize; [2] is the previous value used for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnv_sync  <= '1;
            cs_sync   <= '1;
            sclk_sync <= '1;
            cnv_fall  <= 1'b0;
            cs_fall   <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            cnv_sync  <= {cnv_sync[1:0], CNVST_ADC};
            cs_sync   <= {cs_sync[1:0], CS_ADC};
            sclk_sync <= {sclk_sync[1:0], SCLK_ADC};
            cnv_fall  <= cnv_sync[2] & ~cnv_sync[1];
            cs_fall   <= cs_sync[2] & ~cs_sync[1];
            sclk_fall <= sclk_sync[2] & ~sclk_sync[1];
        end
    end

    // cs_sync[2] updates on the same edge that raises cs_fall, so the two stay aligned.
    assign cs_low    = ~cs_sync[2];
    assign state_dbg = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            BUSY_ADC  <= 1'b0;
            CONV_DONE <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            BUSY_ADC  <= busy_d;
            CONV_DONE <= load;
            OVERRUN   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        busy_d  = BUSY_ADC;
        ovr_d   = OVERRUN;
        load    = 1'b0;
        case (state)
            ST_IDLE, ST_READY: begin
                // The detection cycle is the first of the CONV_DLY delay cycles.
                if (cnv_fall) begin
                    state_d = ST_DELAY;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DELAY: begin
                if (cnv_fall) ovr_d = 1'b1;
                if (cnt == DLY_LAST) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnv_fall) ovr_d = 1'b1;
                if (cnt == BUSY_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Load has priority over any shift or frame start in the same cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_a      <= '0;
            sh_b      <= '0;
            bit_cnt   <= '0;
            DOUTA_ADC <= 1'b0;
            DOUTB_ADC <= 1'b0;
        end else if (load) begin
            sh_a <= src_a;
            sh_b <= src_b;
            if (cs_low) begin
                DOUTA_ADC <= src_a[DATA_W-1];
                DOUTB_ADC <= src_b[DATA_W-1];
                bit_cnt   <= BIT_W'(1);
            end else begin
                DOUTA_ADC <= 1'b0;
                DOUTB_ADC <= 1'b0;
                bit_cnt   <= '0;
            end
        end else if (!cs_low) begin
            DOUTA_ADC <= 1'b0;
            DOUTB_ADC <= 1'b0;
            bit_cnt   <= '0;
        end else if (cs_fall) begin
            DOUTA_ADC <= sh_a[DATA_W-1];
            DOUTB_ADC <= sh_b[DATA_W-1];
            bit_cnt   <= BIT_W'(1);
        end else if (sclk_fall) begin
            if (bit_cnt < BIT_FULL) begin
                sh_a      <= {sh_a[DATA_W-2:0], 1'b0};
                sh_b      <= {sh_b[DATA_W-2:0], 1'b0};
                DOUTA_ADC <= sh_a[DATA_W-2];
                DOUTB_ADC <= sh_b[DATA_W-2];
                bit_cnt   <= bit_cnt + 1'b1;
            end else begin
                DOUTA_ADC <= 1'b0;
                DOUTB_ADC <= 1'b0;
            end
        end
    end

`ifdef ADC_EMU_PATTERN_EN
    logic [DATA_W-1:0] pat_cnt;
    logic              unused_data;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) pat_cnt <= '0;
        else if (load) pat_cnt <= pat_cnt + 1'b1;
    end

    assign src_a       = pat_cnt;
    assign src_b       = ~pat_cnt;
    assign unused_data = ^{DATA_A, DATA_B};
`else
    assign src_a = DATA_A;
    assign src_b = DATA_B;
`endif

endmodule

// File: tb/tb_adc_emulator.sv
// Directed bench for adc_emulator: conversion timing, serial read, overrun, load-during-frame, reset.
// With ADC_EMU_PATTERN_EN defined, runs the counting-pattern sequence instead.
module tb_adc_emulator;

    logic        clk, rst_n;
    logic        cnvst, cs, sclk;
    logic [15:0] data_a, data_b;
    logic        busy, douta, doutb, conv_done, overrun;
    logic [1:0]  state_dbg;

    int n_vec = 0;
    int n_err = 0;

    adc_emulator #(.DATA_W(16), .CONV_DLY(4), .BUSY_CYC(70)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .CNVST_ADC (cnvst),
        .CS_ADC    (cs),
        .SCLK_ADC  (sclk),
        .DATA_A    (data_a),
        .DATA_B    (data_b),
        .BUSY_ADC  (busy),
        .DOUTA_ADC (douta),
        .DOUTB_ADC (doutb),
        .CONV_DONE (conv_done),
        .OVERRUN   (overrun),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // CNVST low pulse at t=0; optional second falling edge at tick extra_at.
    task automatic conv(input int extra_at, output int rise, output int width,
                        output int dones, output int done_t);
        rise = -1; width = 0; dones = 0; done_t = -1;
        cnvst = 1'b0;
        for (int t = 1; t <= 150; t++) begin
            tick_n(1);
            if (busy && rise < 0) rise = t;
            if (busy) width++;
            if (conv_done) begin
                dones++;
                done_t = t;
            end
            if (t == 5) cnvst = 1'b1;
            if (extra_at > 0 && t == extra_at) cnvst = 1'b0;
            if (extra_at > 0 && t == extra_at + 5) cnvst = 1'b1;
        end
    endtask

    // Reader: MSB after CS falls, then one bit per SCLK fall; tail holds DOUT after falls 16 and 17.
    task automatic read_word(output logic [15:0] a, output logic [15:0] b, output logic [3:0] tail);
        cs = 1'b0;
        tick_n(5);
        a[15] = douta;
        b[15] = doutb;
        for (int i = 14; i >= 0; i--) begin
            sclk = 1'b1; tick_n(5);
            sclk = 1'b0; tick_n(5);
            a[i] = douta;
            b[i] = doutb;
        end
        sclk = 1'b1; tick_n(5);
        sclk = 1'b0; tick_n(5);
        tail[3:2] = {douta, doutb};
        sclk = 1'b1; tick_n(5);
        sclk = 1'b0; tick_n(5);
        tail[1:0] = {douta, doutb};
        cs = 1'b1;
        tick_n(5);
    endtask

    int          rise, width, dones, done_t;
    logic [15:0] rd_a, rd_b;
    logic [3:0]  tail;

    initial begin
        rst_n  = 1'b0;
        cnvst  = 1'b1;
        cs     = 1'b1;
        sclk   = 1'b0;
        data_a = 16'hA5C3;
        data_b = 16'h0F0F;
        tick_n(3);
        rst_n = 1'b1;
        tick_n(5);

        check("rst_busy", busy, 0);
        check("rst_douta", douta, 0);
        check("rst_doutb", doutb, 0);
        check("rst_done", conv_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", state_dbg, 0);

`ifdef ADC_EMU_PATTERN_EN
        for (int k = 0; k < 3; k++) begin
            conv(0, rise, width, dones, done_t);
            check("pat_rise", rise, 7);
            check("pat_width", width, 70);
            read_word(rd_a, rd_b, tail);
            check("pat_a", rd_a, 32'(k));
            check("pat_b", rd_b, 32'(16'hFFFF - 16'(k)));
        end
`else
        // Basic conversion
        conv(0, rise, width, dones, done_t);
        check("basic_rise", rise, 7);
        check("basic_width", width, 70);
        check("basic_dones", dones, 1);
        check("basic_done_t", done_t, 77);
        check("basic_overrun", overrun, 0);
        check("basic_state", state_dbg, 3);

        // Serial read
        read_word(rd_a, rd_b, tail);
        check("read_a", rd_a, 16'hA5C3);
        check("read_b", rd_b, 16'h0F0F);
        check("read_tail", tail, 4'b0000);
        check("read_idle_a", douta, 0);

        // Overrun: second edge 30 cycles into BUSY
        conv(37, rise, width, dones, done_t);
        check("ovr_rise", rise, 7);
        check("ovr_width", width, 70);
        check("ovr_dones", dones, 1);
        check("ovr_flag", overrun, 1);

        // New conversion from READY
        conv(0, rise, width, dones, done_t);
        check("ready_rise", rise, 7);
        check("ready_width", width, 70);
        check("ready_overrun", overrun, 1);

        // Load during frame: CS low across the BUSY exit
        data_a = 16'h1234;
        data_b = 16'hFEDC;
        cnvst  = 1'b0;
        cs     = 1'b0;
        done_t = -1;
        for (int t = 1; t <= 150; t++) begin
            tick_n(1);
            if (t == 5) begin
                cnvst = 1'b1;
                check("lf_msb_old_a", douta, 1);
                check("lf_msb_old_b", doutb, 0);
            end
            if (t == 20) check("lf_b14_old_a", douta, 0);
            if (t == 30) begin
                check("lf_b13_old_a", douta, 1);
                check("lf_b13_old_b", doutb, 0);
            end
            if (t == 10 || t == 20) sclk = 1'b1;
            if (t == 15 || t == 25) sclk = 1'b0;
            if (conv_done) begin
                done_t = t;
                break;
            end
        end
        check("lf_done_t", done_t, 77);
        check("lf_new_msb_a", douta, 0);
        check("lf_new_msb_b", doutb, 1);
        rd_a[15] = douta;
        rd_b[15] = doutb;
        for (int i = 14; i >= 0; i--) begin
            sclk = 1'b1; tick_n(5);
            sclk = 1'b0; tick_n(5);
            rd_a[i] = douta;
            rd_b[i] = doutb;
        end
        sclk = 1'b1; tick_n(5);
        sclk = 1'b0; tick_n(5);
        check("lf_word_a", rd_a, 16'h1234);
        check("lf_word_b", rd_b, 16'hFEDC);
        check("lf_tail", {douta, doutb}, 2'b00);
        cs = 1'b1;
        tick_n(10);

        // Reset mid-BUSY
        data_a = 16'h8001;
        data_b = 16'h8001;
        conv(0, rise, width, dones, done_t);
        cnvst = 1'b0;
        cs    = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            tick_n(1);
            if (t == 5) cnvst = 1'b1;
        end
        check("pre_rst_busy", busy, 1);
        check("pre_rst_douta", douta, 1);
        check("pre_rst_doutb", doutb, 1);
        check("pre_rst_overrun", overrun, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_douta", douta, 0);
        check("mid_rst_doutb", doutb, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_state", state_dbg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cs    = 1'b1;
        tick_n(5);
        conv(0, rise, width, dones, done_t);
        check("post_rst_rise", rise, 7);
        check("post_rst_width", width, 70);
        check("post_rst_dones", dones, 1);
        check("post_rst_overrun", overrun, 0);
        read_word(rd_a, rd_b, tail);
        check("post_rst_a", rd_a, 16'h8001);
        check("post_rst_b", rd_b, 16'h8001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
